// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel window generator.
package sobel_pkg;

    localparam int DEFAULT_IMG_WIDTH  = 352;
    localparam int DEFAULT_IMG_HEIGHT = 288;

    typedef logic [7:0] pixel_t;

    // Indexed [row][col]; index 0 is the oldest row (top) and oldest column (left).
    typedef pixel_t [2:0][2:0] window_t;

    typedef enum logic {
        FILL,
        STREAM
    } win_state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of pixel storage: asynchronous read, synchronous write.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = DEFAULT_IMG_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pixel_t        wdata,
    output pixel_t        rdata
);

    pixel_t mem [DEPTH];

    // Storage is deliberately not reset; every entry is rewritten before it is used.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the Sobel kernel.
// Optional feature: define SOBEL_WIN_COORD_EN to add win_row/win_col centre coordinates.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        win_valid,
    input  logic        win_ready,
    output logic        win_last,
`ifdef SOBEL_WIN_COORD_EN
    output logic [15:0] win_row,
    output logic [15:0] win_col,
`endif
    output logic [7:0]  s11,
    output logic [7:0]  s12,
    output logic [7:0]  s13,
    output logic [7:0]  s21,
    output logic [7:0]  s22,
    output logic [7:0]  s23,
    output logic [7:0]  s31,
    output logic [7:0]  s32,
    output logic [7:0]  s33
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    win_state_t    state;
    win_state_t    next_state;
    window_t       win;
    pixel_t        lb0_rd;
    pixel_t        lb1_rd;
    logic          accept;
    logic          produce;

    // The window only shifts when the presented window is gone or being taken this cycle.
    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready;

    // lb0 holds the previous row, lb1 the row before; lb1 inherits lb0's old value on write.
    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .AW    (CW)
    ) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (in_data),
        .rdata (lb0_rd)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .AW    (CW)
    ) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // Raster position of the next pixel to be accepted; wraps straight into the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    // STREAM covers rows 2 and up; a window is produced only once three real columns are loaded.
    always_comb begin
        next_state = state;
        produce    = 1'b0;
        if (accept) begin
            if (state == STREAM && col >= COL_TWO) begin
                produce = 1'b1;
            end
            if (col == COL_LAST) begin
                if (row == ROW_LAST) begin
                    next_state = FILL;
                end else if (row == ROW_ONE) begin
                    next_state = STREAM;
                end
            end
        end
    end

    // Shift the window left on every accept, loading the new right column from the buffers and input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1_rd;
            win[1][2] <= lb0_rd;
            win[2][2] <= in_data;
        end
    end

    // Output qualifier: new window replaces the old one with no bubble, else clears on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (produce) begin
            win_valid <= 1'b1;
            win_last  <= (row == ROW_LAST) && (col == COL_LAST);
        end else if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end
    end

`ifdef SOBEL_WIN_COORD_EN
    // Centre coordinates lag the completing accept by one row and one column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_row <= '0;
            win_col <= '0;
        end else if (produce) begin
            win_row <= 16'(row) - 16'd1;
            win_col <= 16'(col) - 16'd1;
        end
    end
`endif

    assign s11 = win[0][0];
    assign s12 = win[0][1];
    assign s13 = win[0][2];
    assign s21 = win[1][0];
    assign s22 = win[1][1];
    assign s23 = win[1][2];
    assign s31 = win[2][0];
    assign s32 = win[2][1];
    assign s33 = win[2][2];

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator feeding the combinational `sobel` kernel. It accepts a raster-order 8-bit greyscale pixel stream using a valid/ready handshake and stores the two previous image rows in line buffers. For every interior pixel it presents the nine neighbours on `s11..s33`, where `sRC` means R = row (1 = oldest/top) and C = column (1 = oldest/left). The window outputs connect one-to-one to the kernel's inputs, and the kernel's result is qualified by `win_valid`.

## Interface
Parameters:
- `IMG_WIDTH`, default 352: pixels per row; must be ≥ 3.
- `IMG_HEIGHT`, default 288: rows per frame; must be ≥ 3.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: `in_data` holds a pixel.
- `in_ready`, output, 1: block can accept a pixel.
- `in_data`, input, 8: pixel value, raster order.
- `win_valid`, output, 1: window outputs are valid.
- `win_ready`, input, 1: consumer takes the window.
- `win_last`, output, 1: final window of the frame; qualified by `win_valid`.
- `s11, s12, s13, s21, s22, s23, s31, s32, s33`, output, 8 each: 3x3 window.

## Operation
- Accept event: `in_valid && in_ready`.
- Position counters: `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1).
  - `col` advances on each accept.
  - At `col == IMG_WIDTH-1`, `col` wraps to 0 and `row` increments.
  - At (`IMG_HEIGHT-1`, `IMG_WIDTH-1`), both wrap to 0. There is no inter-frame gap.
- Line buffers: `lb0` holds row r-1 and `lb1` holds row r-2, each `IMG_WIDTH` x 8.
  - Reads are asynchronous.
  - On accept at column c: read `lb1[c]` and `lb0[c]`, write `lb1[c] <= lb0[c]` and `lb0[c] <= in_data`.
- Window shift on accept: column 1 <= column 2, column 2 <= column 3, new column 3 = {`s13 = lb1[c]`, `s23 = lb0[c]`, `s33 = in_data`}.
- The window registers are the output registers. `in_ready = !win_valid || win_ready`, so the window never shifts while a presented window is unconsumed.
- FSM states:
  - `FILL`: `row < 2`. Accepts pixels, produces no windows.
  - `STREAM`: `row >= 2`. Entered on the accept that wraps `col` into row 2; returns to `FILL` on the frame-wrap accept.
- `win_valid` next-state rules:
  - Set to 1 on an accept in `STREAM` with `col >= 2`.
  - Otherwise cleared when `win_ready` is high.
  - Otherwise held.
- Accepts at `col` 0 and 1 shift the window (priming it with the new row) but produce no window. Stale columns from the previous row are never presented.
- The window produced by the accept at (r, c) is centred on pixel (r-1, c-1).
- `win_last` = 1 for the window produced by the accept at (`IMG_HEIGHT-1`, `IMG_WIDTH-1`), and 0 otherwise.
- Windows per frame: exactly `(IMG_WIDTH-2)*(IMG_HEIGHT-2)`. Border pixels get no window.
- Line buffer contents carry over between frames. The next frame's `FILL` rows overwrite them before any use.

## Timing
- Reset values: `in_ready` = 1, `win_valid` = 0, `win_last` = 0, all `s*` = 0, counters = 0, FSM = `FILL`. Line buffer RAM is not reset.
- Latency: the window appears in the cycle after its completing accept, with `win_valid` registered.
- Throughput: one pixel per cycle while `win_ready` is held high.
- Backpressure: while `win_valid && !win_ready`, `in_ready` = 0 and all window outputs are stable.
- Simultaneous consume and accept in the same cycle: the new window replaces the old one with no bubble.
- Reset asserted mid-frame: output drops immediately to reset values. After release, the next accepted pixel is treated as (0,0).

## Configuration
- `SOBEL_WIN_COORD_EN` defined: adds outputs `win_row` and `win_col`, each 16 bits, qualified by `win_valid`.
  - They give the centre pixel coordinates (r-1, c-1) and are held with the window.
  - Reset value is 0.
- `SOBEL_WIN_COORD_EN` not defined: these ports and their registers are absent. Behaviour is otherwise identical.

## Structure
- Package `sobel_pkg`:
  - `pixel_t` (logic [7:0]).
  - `window_t` (packed 3x3 of `pixel_t`).
  - FSM enum `win_state_t` {`FILL`, `STREAM`}.
  - Default `IMG_WIDTH` and `IMG_HEIGHT` constants.
- Sub-module `sobel_line_buffer`: one `IMG_WIDTH`-deep array with asynchronous read and synchronous write. It is instantiated twice.

## Test plan
Parameters for all scenarios: `IMG_WIDTH`=5, `IMG_HEIGHT`=4, pixel value = 10*r + c.
- Full frame with `win_ready`=1:
  - Exactly 6 windows are produced.
  - First window, one cycle after accepting (2,2): `s11..s13` = 0,1,2; `s21..s23` = 10,11,12; `s31..s33` = 20,21,22.
  - Last window: `s33` = 34 with `win_last` = 1.
- Backpressure: drop `win_ready` for 5 cycles while a window is valid.
  - `in_ready` = 0 and `s11..s33` remain constant for those cycles.
  - After release, the window sequence is intact with no loss or duplication.
- Random `in_valid` gaps combined with random `win_ready`: the window sequence matches a golden model and `win_last` count = 1.
- Back-to-back frames (second frame uses pixel + 100): the second frame's first window has `s11` = 100, and no window mixes the two frames.
- Reset asserted after 8 accepts:
  - Outputs are immediately 0 and `in_ready` = 1.
  - A following full frame yields the same 6 windows as the first scenario.
- With `SOBEL_WIN_COORD_EN` defined: the first window has `win_row`=1, `win_col`=1; the last has `win_row`=2, `win_col`=3.
